// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped write-back cache.
package cache_pkg;

    localparam int CACHE_LINES   = 16;
    localparam int CACHE_LATENCY = 4;
    localparam int CACHE_WIDTH   = 128;
    localparam int CACHE_ADDR    = 32;

    // Controller states; the encoding is visible on the debug port.
    typedef enum logic [1:0] {
        CACHE_IDLE = 2'd0,
        CACHE_WB   = 2'd1,
        CACHE_FILL = 2'd2,
        CACHE_UNC  = 2'd3
    } cache_state_e;

endpackage

// File: rtl/cache_if.sv
// CPU-side and memory-side bus of the cache.
//
// CPU handshake: a request is memread and/or memwrite with addr/wdata. While
// stall is high the requester must hold addr, wdata, memread and memwrite
// unchanged; the request completes on the rising edge at which stall is low
// (rdata is valid in that cycle for loads). Memory side has no handshake:
// mem_read/mem_write are held for as many cycles as the memory needs and
// mem_rdata is valid combinationally while mem_read is high.
interface cache_if
    import cache_pkg::*;
#(
    parameter int ADDR  = CACHE_ADDR,
    parameter int WIDTH = CACHE_WIDTH
);
    logic [ADDR-1:0]  addr;
    logic [31:0]      wdata;
    logic             memread;
    logic             memwrite;
    logic [31:0]      rdata;
    logic             stall;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_rdata;

    // Requester and memory model side (testbench / pipeline + memory).
    modport master (
        output addr, wdata, memread, memwrite, mem_rdata,
        input  rdata, stall, mem_addr, mem_wdata, mem_read, mem_write
    );

    // Cache side.
    modport slave (
        input  addr, wdata, memread, memwrite, mem_rdata,
        output rdata, stall, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/cache_store.sv
// Valid/dirty/tag/data arrays: combinational read, synchronous word write and line fill.
module cache_store
    import cache_pkg::*;
#(
    parameter int WIDTH = CACHE_WIDTH,
    parameter int LINES = CACHE_LINES,
    parameter int TAGW  = 24,
    parameter int IB    = 4,
    parameter int WB    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IB-1:0]    idx,
    output logic             rd_valid,
    output logic             rd_dirty,
    output logic [TAGW-1:0]  rd_tag,
    output logic [WIDTH-1:0] rd_line,
    input  logic             wr_en,
    input  logic [WB-1:0]    wr_word,
    input  logic [31:0]      wr_data,
    input  logic             fill_en,
    input  logic [TAGW-1:0]  fill_tag,
    input  logic [WIDTH-1:0] fill_line
);
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAGW-1:0]  tag_q  [LINES];
    logic [WIDTH-1:0] data_q [LINES];

    // Combinational lookup of the addressed line.
    always_comb begin
        rd_valid = valid_q[idx];
        rd_dirty = dirty_q[idx];
        rd_tag   = tag_q[idx];
        rd_line  = data_q[idx];
    end

    // Status bits: cleared on reset, set by fill (clean) or store (dirty).
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; a fill replaces the whole line.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (wr_en) begin
            data_q[idx][32*wr_word +: 32] <= wr_data;
        end
    end

endmodule

// File: rtl/cache.sv
// Direct-mapped write-back write-allocate cache with an uncached top line.
module cache
    import cache_pkg::*;
#(
    parameter int WIDTH        = CACHE_WIDTH,
    parameter int MEMORY_WIDTH = WIDTH,
    parameter int LINES        = CACHE_LINES,
    parameter int ADDR         = CACHE_ADDR,
    parameter int LATENCY      = CACHE_LATENCY
) (
    input  logic         clk,
    input  logic         reset,
    cache_if.slave       bus,
    output cache_state_e state_dbg
);
    localparam int OB   = $clog2(WIDTH / 8);
    localparam int IB   = $clog2(LINES);
    localparam int TAGW = ADDR - OB - IB;
    localparam int WB   = OB - 2;
    localparam int CW   = $clog2(LATENCY + 1);

    cache_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IB-1:0]    idx;
    logic [TAGW-1:0]  tag_in;
    logic [WB-1:0]    word;
    logic             uncached;
    logic             req;
    logic             hit;
    logic             cnt_last;
    logic [1:0]       unused_addr_bits;

    logic             rd_valid;
    logic             rd_dirty;
    logic [TAGW-1:0]  rd_tag;
    logic [WIDTH-1:0] rd_line;
    logic             wr_en;
    logic             fill_en;

    logic [31:0]      rdata;
    logic             stall;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_read;
    logic             mem_write;

    assign idx              = bus.addr[OB+IB-1:OB];
    assign tag_in           = bus.addr[ADDR-1:OB+IB];
    assign word             = bus.addr[OB-1:2];
    assign uncached         = &bus.addr[ADDR-1:OB];
    assign req              = bus.memread | bus.memwrite;
    assign hit              = rd_valid && (rd_tag == tag_in);
    assign cnt_last         = (cnt_q == CW'(LATENCY - 1));
    assign unused_addr_bits = bus.addr[1:0];

    cache_store #(
        .WIDTH (WIDTH),
        .LINES (LINES),
        .TAGW  (TAGW),
        .IB    (IB),
        .WB    (WB)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .idx       (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_word   (word),
        .wr_data   (bus.wdata),
        .fill_en   (fill_en),
        .fill_tag  (tag_in),
        .fill_line (bus.mem_rdata)
    );

    // State and transfer-cycle counter; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CACHE_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, stall, memory strobes and CPU data; everything idles during reset.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        rdata     = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wr_en     = 1'b0;
        fill_en   = 1'b0;
        if (!reset) begin
            case (state_q)
                CACHE_IDLE: begin
                    if (req) begin
                        if (uncached) begin
                            stall   = 1'b1;
                            state_d = CACHE_UNC;
                        end else if (hit) begin
                            // Store wins when both strobes are high; rdata shows the old word.
                            if (bus.memread) rdata = rd_line[32*word +: 32];
                            if (bus.memwrite) wr_en = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            cnt_d   = '0;
                            state_d = (rd_valid && rd_dirty) ? CACHE_WB : CACHE_FILL;
                        end
                    end
                end
                CACHE_WB: begin
                    stall     = 1'b1;
                    mem_write = 1'b1;
                    mem_addr  = {rd_tag, idx, {OB{1'b0}}};
                    mem_wdata = rd_line;
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = CACHE_FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CACHE_FILL: begin
                    stall    = 1'b1;
                    mem_read = 1'b1;
                    mem_addr = {tag_in, idx, {OB{1'b0}}};
                    if (cnt_last) begin
                        fill_en = 1'b1;
                        cnt_d   = '0;
                        state_d = CACHE_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CACHE_UNC: begin
                    if (bus.memwrite) begin
                        mem_write = 1'b1;
                        mem_addr  = bus.addr;
                        mem_wdata = {{(MEMORY_WIDTH-32){1'b0}}, bus.wdata};
                    end else if (bus.memread) begin
                        mem_read = 1'b1;
                        mem_addr = bus.addr;
                        rdata    = bus.mem_rdata[31:0];
                    end
                    state_d = CACHE_IDLE;
                end
                default: state_d = CACHE_IDLE;
            endcase
        end
    end

    assign bus.rdata     = rdata;
    assign bus.stall     = stall;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_cache.sv
// Directed bench for the cache: cold miss, hits, dirty eviction, uncached
// accesses, reset during fill and load+store on a hit.
module tb_cache;
    import cache_pkg::*;

    logic         clk;
    logic         reset;
    cache_state_e state_dbg;
    int           checks;
    int           errors;

    cache_if bus_if ();

    cache dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .state_dbg (state_dbg)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word i of the line at base B reads (B + 4*i) ^ 0xC0DE0000.
    always_comb begin
        logic [31:0] base;
        base = {bus_if.mem_addr[31:4], 4'b0000};
        for (int i = 0; i < 4; i++)
            bus_if.mem_rdata[32*i +: 32] = (base + 32'(4*i)) ^ 32'hC0DE0000;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
        bus_if.addr     = a;
        bus_if.wdata    = d;
        bus_if.memread  = rd;
        bus_if.memwrite = wr;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic st, input logic rd, input logic wr,
                             input logic [31:0] ma);
        check({tag, ".stall"}, 128'(bus_if.stall), 128'(st));
        check({tag, ".mem_read"}, 128'(bus_if.mem_read), 128'(rd));
        check({tag, ".mem_write"}, 128'(bus_if.mem_write), 128'(wr));
        check({tag, ".mem_addr"}, 128'(bus_if.mem_addr), 128'(ma));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst.stall", 128'(bus_if.stall), 128'(0));
        check("rst.mem_read", 128'(bus_if.mem_read), 128'(0));
        check("rst.mem_write", 128'(bus_if.mem_write), 128'(0));
        check("rst.rdata", 128'(bus_if.rdata), 128'(0));
        check("rst.mem_addr", 128'(bus_if.mem_addr), 128'(0));
        check("rst.mem_wdata", bus_if.mem_wdata, 128'(0));
        check("rst.state", 128'(state_dbg), 128'(CACHE_IDLE));
        reset = 1'b0;

        // Cold load of 0x40: detect cycle, 4 fill cycles, hit in cycle 5.
        drive(32'h40, 32'h0, 1'b1, 1'b0);
        check_bus("cold.c0", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            check_bus($sformatf("cold.c%0d", k), 1'b1, 1'b1, 1'b0, 32'h40);
            check("cold.state", 128'(state_dbg), 128'(CACHE_FILL));
        end
        next_cycle();
        check_bus("cold.c5", 1'b0, 1'b0, 1'b0, 32'h0);
        check("cold.rdata", 128'(bus_if.rdata), 128'(32'hC0DE0040));
        next_cycle();

        // Store hit then load hit on the same line.
        drive(32'h44, 32'hDEADBEEF, 1'b0, 1'b1);
        check_bus("sthit", 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(32'h44, 32'h0, 1'b1, 1'b0);
        check_bus("ldhit", 1'b0, 1'b0, 1'b0, 32'h0);
        check("ldhit.rdata", 128'(bus_if.rdata), 128'(32'hDEADBEEF));
        next_cycle();

        // Dirty eviction: load 0x144 shares index 4 with the dirty 0x40 line.
        drive(32'h144, 32'h0, 1'b1, 1'b0);
        check_bus("dirty.c0", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            check_bus($sformatf("dirty.wb%0d", k), 1'b1, 1'b0, 1'b1, 32'h40);
            check("dirty.wdata", bus_if.mem_wdata,
                  128'h C0DE004C_C0DE0048_DEADBEEF_C0DE0040);
            check("dirty.state", 128'(state_dbg), 128'(CACHE_WB));
        end
        for (int k = 5; k <= 8; k++) begin
            next_cycle();
            check_bus($sformatf("dirty.fill%0d", k), 1'b1, 1'b1, 1'b0, 32'h140);
        end
        next_cycle();
        check_bus("dirty.c9", 1'b0, 1'b0, 1'b0, 32'h0);
        check("dirty.rdata", 128'(bus_if.rdata), 128'(32'hC0DE0144));
        next_cycle();

        // Uncached store to the top line.
        drive(32'hFFFFFFFC, 32'h41, 1'b0, 1'b1);
        check_bus("unst.c0", 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        check_bus("unst.c1", 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
        check("unst.wdata", bus_if.mem_wdata, 128'h41);
        check("unst.state", 128'(state_dbg), 128'(CACHE_UNC));
        next_cycle();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check("unst.back", 128'(state_dbg), 128'(CACHE_IDLE));

        // Uncached load returns the low word of the memory line.
        drive(32'hFFFFFFF0, 32'h0, 1'b1, 1'b0);
        check_bus("unld.c0", 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        check_bus("unld.c1", 1'b0, 1'b1, 1'b0, 32'hFFFFFFF0);
        check("unld.rdata", 128'(bus_if.rdata), 128'(32'h3F21FFF0));
        next_cycle();

        // Index 15 was not allocated by the uncached accesses: clean miss.
        drive(32'hF0, 32'h0, 1'b1, 1'b0);
        check_bus("idx15.c0", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) next_cycle();
        check_bus("idx15.c4", 1'b1, 1'b1, 1'b0, 32'hF0);
        next_cycle();
        check_bus("idx15.c5", 1'b0, 1'b0, 1'b0, 32'h0);
        check("idx15.rdata", 128'(bus_if.rdata), 128'(32'hC0DE00F0));
        next_cycle();

        // Reset during FILL cycle 2 aborts the fill.
        drive(32'h80, 32'h0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        check("rfill.state", 128'(state_dbg), 128'(CACHE_FILL));
        reset = 1'b1;
        drive(32'h80, 32'h0, 1'b0, 1'b0);
        check_bus("rfill.inrst", 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        reset = 1'b0;
        #1;
        check("rfill.idle", 128'(state_dbg), 128'(CACHE_IDLE));
        check_bus("rfill.after", 1'b0, 1'b0, 1'b0, 32'h0);
        drive(32'h80, 32'h0, 1'b1, 1'b0);
        check_bus("rfill.remiss", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) next_cycle();
        next_cycle();
        check("rfill.rdata", 128'(bus_if.rdata), 128'(32'hC0DE0080));
        next_cycle();

        // Store 0x11 to 0x48 (write-allocate), then load+store returns old word.
        drive(32'h48, 32'h11, 1'b0, 1'b1);
        check_bus("both.c0", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) next_cycle();
        next_cycle();
        check_bus("both.c5", 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(32'h48, 32'h22, 1'b1, 1'b1);
        check("both.stall", 128'(bus_if.stall), 128'(0));
        check("both.rdata", 128'(bus_if.rdata), 128'(32'h11));
        next_cycle();
        drive(32'h48, 32'h0, 1'b1, 1'b0);
        check("both.after", 128'(bus_if.rdata), 128'(32'h22));
        check("both.nowrite", 128'(bus_if.mem_write), 128'(0));
        next_cycle();
        drive(32'h0, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
